// File: rtl/vedic8x8_pipe.sv
// 8x8 unsigned multiplier built from four 4x4 Vedic (Urdhva Tiryagbhyam)
// multipliers, in a 3-stage valid/ready pipeline:
// operand register -> partial-product register -> output register.

// 4x4 Vedic multiplier built from 2x2 vertical-and-crosswise cells.
// ground feeds the carry-in of the middle adder.
module vedic4x4 (
    input  logic       ground,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] prod,
    output logic       overflow
);

    // 2x2 Vedic cell: the crosswise terms are combined with a half adder.
    function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
        logic c1;
        logic [3:0] p;
        p[0] = x[0] & y[0];
        p[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
        c1   = (x[1] & y[0]) & (x[0] & y[1]);
        p[2] = (x[1] & y[1]) ^ c1;
        p[3] = (x[1] & y[1]) & c1;
        return p;
    endfunction

    logic [3:0] q0, q1, q2, q3;
    logic [4:0] mid;

    // Combine the four 2x2 partials; the top adder bit is exposed as overflow.
    always_comb begin
        q0  = vedic2x2(a[1:0], b[1:0]);
        q1  = vedic2x2(a[1:0], b[3:2]);
        q2  = vedic2x2(a[3:2], b[1:0]);
        q3  = vedic2x2(a[3:2], b[3:2]);
        mid = {1'b0, q1} + {1'b0, q2} + {4'b0000, ground};
        {overflow, prod} = {5'b00000, q0} + {2'b00, mid, 2'b00} + {1'b0, q3, 4'b0000};
    end

endmodule

module vedic8x8_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        ground,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] prod,
    output logic        busy
);

    logic        v1, v2, v3;
    logic        adv1, adv2, adv3;
    logic [7:0]  opa, opb;
    logic [7:0]  pp0, pp1, pp2, pp3;
    logic [7:0]  pp0_c, pp1_c, pp2_c, pp3_c;
    logic [3:0]  unused_ovf;
    logic [8:0]  mid_sum;
    logic [15:0] prod_c;

    vedic4x4 u_m0 (.ground(ground), .a(opa[3:0]), .b(opb[3:0]), .prod(pp0_c), .overflow(unused_ovf[0]));
    vedic4x4 u_m1 (.ground(ground), .a(opa[3:0]), .b(opb[7:4]), .prod(pp1_c), .overflow(unused_ovf[1]));
    vedic4x4 u_m2 (.ground(ground), .a(opa[7:4]), .b(opb[3:0]), .prod(pp2_c), .overflow(unused_ovf[2]));
    vedic4x4 u_m3 (.ground(ground), .a(opa[7:4]), .b(opb[7:4]), .prod(pp3_c), .overflow(unused_ovf[3]));

    // Handshake: each stage moves when its predecessor is full and its own
    // slot is empty or being vacated downstream in the same cycle.
    always_comb begin
        adv3      = v2 & (~v3 | out_ready);
        adv2      = v1 & (~v2 | adv3);
        in_ready  = ~v1 | adv2;
        adv1      = in_valid & in_ready;
        out_valid = v3;
        busy      = v1 | v2 | v3;
    end

    // Final recombination; the 9-bit middle sum keeps its carry.
    always_comb begin
        mid_sum = {1'b0, pp1} + {1'b0, pp2};
        prod_c  = {8'h00, pp0} + {3'b000, mid_sum, 4'h0} + {pp3, 8'h00};
    end

    // S1: operand register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1  <= 1'b0;
            opa <= '0;
            opb <= '0;
        end else begin
            if (adv1) begin
                v1  <= 1'b1;
                opa <= a;
                opb <= b;
            end else if (adv2) begin
                v1 <= 1'b0;
            end
        end
    end

    // S2: partial-product register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2  <= 1'b0;
            pp0 <= '0;
            pp1 <= '0;
            pp2 <= '0;
            pp3 <= '0;
        end else begin
            if (adv2) begin
                v2  <= 1'b1;
                pp0 <= pp0_c;
                pp1 <= pp1_c;
                pp2 <= pp2_c;
                pp3 <= pp3_c;
            end else if (adv3) begin
                v2 <= 1'b0;
            end
        end
    end

    // S3: output register; holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3   <= 1'b0;
            prod <= '0;
        end else begin
            if (adv3) begin
                v3   <= 1'b1;
                prod <= prod_c;
            end else if (out_ready) begin
                v3 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vedic8x8_pipe.sv
// Scoreboard bench for vedic8x8_pipe: expected products are queued on
// acceptance and compared in order whenever an output is consumed.
module tb_vedic8x8_pipe;

    logic        clk;
    logic        rst;
    logic        ground;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] prod;
    logic        busy;

    logic [15:0] cur_exp;
    logic [15:0] sb[$];
    int          checks = 0;
    int          failures = 0;
    int          n_acc = 0;
    logic        done;

    vedic8x8_pipe dut (
        .clk(clk), .rst(rst), .ground(ground),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .prod(prod), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: push on acceptance, pop/compare on consumption, check hold.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_prod = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_prod", {16'b0, prod}, {16'b0, prev_prod});
            end
            if (in_valid && in_ready) begin
                sb.push_back(cur_exp);
                n_acc++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got %0h expected none at %0t", prod, $time);
                end else begin
                    logic [15:0] e;
                    e = sb.pop_front();
                    check("prod", {16'b0, prod}, {16'b0, e});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_prod  = prod;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] xa, input logic [7:0] xb, input logic [15:0] e);
        int n;
        in_valid = 1'b1;
        a        = xa;
        b        = xb;
        cur_exp  = e;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout: got in_ready=0 expected 1 at %0t", $time);
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Single op with exact latency check: out_valid low for two cycles, high on the third.
    task automatic latency_check(input logic [7:0] xa, input logic [7:0] xb, input logic [15:0] e);
        in_valid = 1'b1;
        a        = xa;
        b        = xb;
        cur_exp  = e;
        check("lat_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("lat_c1_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1 check("lat_c2_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1 check("lat_c3_valid", {31'b0, out_valid}, 32'd1);
        check("lat_c3_prod", {16'b0, prod}, {16'b0, e});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ground = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cur_exp = '0; done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_prod", {16'b0, prod}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single op, first after reset
        latency_check(8'd13, 8'd11, 16'h008F);
        idle(2);

        // Corners back to back
        send(8'd255, 8'd255, 16'hFE01);
        send(8'd0,   8'd200, 16'h0000);
        send(8'd1,   8'd255, 16'h00FF);
        send(8'd16,  8'd16,  16'h0100);
        idle(6);

        // Backpressure then simultaneous release
        begin
            int base;
            base = n_acc;
            out_ready = 1'b0;
            fork
                begin
                    send(8'd3,   8'd5,   16'h000F);
                    send(8'd100, 8'd3,   16'h012C);
                    send(8'd17,  8'd17,  16'h0121);
                    send(8'd200, 8'd2,   16'h0190);
                    send(8'd128, 8'd128, 16'h4000);
                end
                begin
                    repeat (6) @(posedge clk);
                    #2;
                    check("bp_in_ready", {31'b0, in_ready}, 32'd0);
                    check("bp_accepts", n_acc - base, 32'd3);
                    check("bp_out_valid", {31'b0, out_valid}, 32'd1);
                    check("bp_prod", {16'b0, prod}, 32'h000F);
                    check("bp_busy", {31'b0, busy}, 32'd1);
                    out_ready = 1'b1;
                    #1 check("release_in_ready", {31'b0, in_ready}, 32'd1);
                    for (int i = 0; i < 5; i++) begin
                        @(negedge clk);
                        check("release_no_gap", {31'b0, out_valid}, 32'd1);
                    end
                end
            join
        end
        idle(6);

        // Reset mid-stream with two ops in flight
        send(8'd50, 8'd50, 16'h09C4);
        send(8'd9,  8'd9,  16'h0051);
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_prod", {16'b0, prod}, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        latency_check(8'd7, 8'd9, 16'd63);
        idle(2);

        // Random traffic
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    logic [7:0] ra, rb;
                    ra = 8'($urandom);
                    rb = 8'($urandom);
                    repeat ($urandom_range(0, 1)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(ra, rb, 16'(ra) * 16'(rb));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #1;
        check("drain_empty", sb.size(), 32'd0);
        check("drain_busy", {31'b0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vedic8x8_pipe.md
VEDIC8X8_PIPE -- requirements
Module: vedic8x8_pipe

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 8x8 -> 16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port ground, input, 1 bit: tied to 0 at top level and forwarded to every vedic4x4 instance ground pin.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands a/b are valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-007 The block SHALL have port a, input, 8 bits: multiplicand, unsigned.
REQ-008 The block SHALL have port b, input, 8 bits: multiplier, unsigned.
REQ-009 The block SHALL have port out_valid, output, 1 bit: prod is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes prod this cycle.
REQ-011 The block SHALL have port prod, output, 16 bits: a*b, unsigned.
REQ-012 The block SHALL have port busy, output, 1 bit: any pipeline stage holds a valid entry.

Function
REQ-013 The block SHALL be a 3-stage pipeline, with stages S1, S2 and S3, each holding a valid bit (v1, v2, v3).
- S1: operand register.
- S2: partial-product register.
- S3: output register.
REQ-014 S1 SHALL capture a/b and set v1 when in_valid and in_ready are both 1.
REQ-015 S2 SHALL take its partials from four vedic4x4 instances driven from the S1 operands:
- pp0 = a[3:0]*b[3:0]
- pp1 = a[3:0]*b[7:4]
- pp2 = a[7:4]*b[3:0]
- pp3 = a[7:4]*b[7:4]
- Each partial is 8 bits.
- The vedic4x4 overflow outputs SHALL be left unused.
REQ-016 S3 SHALL register prod = pp0 + ((pp1 + pp2) << 4) + (pp3 << 8).
- Computed at 16-bit width.
- The 9-bit sum pp1+pp2 keeps its carry.
- No truncation before the final 16 bits.
REQ-017 Stage k SHALL advance (adv_k) when v_{k-1} = 1 and either its own slot is empty or its own slot advances this cycle.
- S3 empties when out_valid and out_ready are both 1.
REQ-018 in_ready SHALL be combinational: in_ready = !v1 | adv2.
- It is 1 whenever a bubble exists anywhere ahead of the operands.
REQ-019 Latency SHALL be 3 cycles from acceptance to out_valid, with no backpressure.
- Throughput SHALL be one result per cycle while out_ready = 1.
REQ-020 When out_valid = 1 and out_ready = 0:
- prod and out_valid SHALL hold stable.
- Upstream stages SHALL fill remaining bubbles, then stall.
- in_ready SHALL drop only once S1, S2 and S3 are all full.
REQ-021 Stage data registers SHALL load only when that stage advances.
- No data SHALL be lost or duplicated under any in_valid/out_ready pattern.
REQ-022 If out_ready rises in the same cycle that S1 is full and in_valid = 1:
- All stages SHALL shift.
- The new operand SHALL be accepted that same cycle.
REQ-023 out_valid SHALL equal v3, and busy SHALL equal v1 | v2 | v3.
REQ-024 out_valid SHALL NOT depend combinationally on out_ready.
REQ-025 Results SHALL emerge in acceptance order.

Reset
REQ-026 On rst = 1, the following SHALL clear asynchronously, regardless of clk:
- v1, v2 and v3.
- prod = 16'h0000.
- All operand and partial registers.
REQ-027 While rst = 1, outputs SHALL read as follows:
- out_valid = 0.
- busy = 0.
- in_ready = 1.
REQ-028 An operand in flight when reset asserts SHALL be discarded.
REQ-029 After reset release, the first accepted operand SHALL produce out_valid exactly 3 cycles later.

Verification
REQ-030 Single op: a=13, b=11, out_ready=1 -> 3 cycles later out_valid=1, prod=143 (16'h008F).
REQ-031 Corners, back-to-back with out_ready=1:
- a=255, b=255 -> 16'hFE01.
- a=0, b=200 -> 16'h0000.
- a=1, b=255 -> 16'h00FF.
- a=16, b=16 -> 16'h0100.
- All four consecutive, one per cycle, in order.
REQ-032 Backpressure: stream 5 ops with out_ready=0 -> in_ready drops after 3 accepts, prod holds the first result. Then raise out_ready -> all 5 results appear in order, with no gaps, duplicates or loss.
REQ-033 Simultaneous release: pipeline full, in_valid=1 and out_ready rises -> the same cycle accepts the new op and outputs the oldest; the new op's result appears 3 cycles later.
REQ-034 Reset mid-stream: assert rst asynchronously with 2 ops in flight -> out_valid, busy and prod clear immediately. After release, a=7, b=9 gives prod=63, 3 cycles after accept.
REQ-035 Random: 10k random a/b with random in_valid/out_ready -> every output matches a*b against a scoreboard, in order.
